// File: rtl/serial_frame_receiver.sv
// Deserializes MSB-first 32-bit serial frames into a 2-entry word buffer with valid/ready output.
// Word visible 2 Clk edges after the final SerClk rise; on a full buffer without a pop the word is dropped.
module serial_frame_receiver #(
  parameter int WORD_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SerData,
  input  logic              SerClk,
  input  logic              SerValid,
  input  logic              RxReady,
  output logic              RxValid,
  output logic [WORD_W-1:0] RxWord,
  output logic [7:0]        FieldA,
  output logic [7:0]        FieldB,
  output logic [7:0]        FieldRes,
  output logic [3:0]        FieldSel,
  output logic [3:0]        FieldFlag,
  output logic              FrameErr,
  output logic              Overrun,
  output logic [7:0]        WordCount
);

  logic              d_ser_data, d_ser_clk, d_ser_valid;
  logic              p_ser_clk, p_ser_valid;
  logic [WORD_W-1:0] shift_reg;
  logic [4:0]        bit_cnt;
  logic [WORD_W-1:0] mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fill;

  logic              bit_evt, frame_end, word_done, pop, full, do_write;
  logic [WORD_W-1:0] new_word;

  // Rising SerClk seen through the registered input stage, qualified by an active frame.
  assign bit_evt   = d_ser_clk & ~p_ser_clk & d_ser_valid;
  assign frame_end = ~d_ser_valid & p_ser_valid;
  assign word_done = bit_evt & (bit_cnt == 5'd31);
  assign new_word  = {shift_reg[WORD_W-2:0], d_ser_data};

  assign RxValid  = (fill != 2'd0);
  assign RxWord   = mem[rd_ptr];
  assign full     = (fill == 2'd2);
  assign pop      = RxValid & RxReady;
  assign do_write = word_done & (~full | pop);

  assign FieldA    = RxWord[31:24];
  assign FieldB    = RxWord[23:16];
  assign FieldRes  = RxWord[15:8];
  assign FieldSel  = RxWord[7:4];
  assign FieldFlag = RxWord[3:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      d_ser_data  <= 1'b0;
      d_ser_clk   <= 1'b0;
      d_ser_valid <= 1'b0;
      p_ser_clk   <= 1'b0;
      p_ser_valid <= 1'b0;
      shift_reg   <= '0;
      bit_cnt     <= 5'd0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fill        <= 2'd0;
      FrameErr    <= 1'b0;
      Overrun     <= 1'b0;
      WordCount   <= 8'd0;
    end else begin
      d_ser_data  <= SerData;
      d_ser_clk   <= SerClk;
      d_ser_valid <= SerValid;
      p_ser_clk   <= d_ser_clk;
      p_ser_valid <= d_ser_valid;

      // bit_cnt wraps 31->0 naturally, so back-to-back frames need no special case.
      if (bit_evt) begin
        shift_reg <= new_word;
        bit_cnt   <= bit_cnt + 5'd1;
      end else if (frame_end) begin
        shift_reg <= '0;
        bit_cnt   <= 5'd0;
      end

      FrameErr <= frame_end & (bit_cnt != 5'd0);
      Overrun  <= word_done & full & ~pop;

      if (do_write) begin
        mem[wr_ptr] <= new_word;
        wr_ptr      <= ~wr_ptr;
        WordCount   <= WordCount + 8'd1;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fill <= fill + {1'b0, do_write} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: scoreboard of expected words checked on every pop.
module tb_serial_frame_receiver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        SerData = 1'b0, SerClk = 1'b0, SerValid = 1'b0, RxReady = 1'b0;
  logic        RxValid, FrameErr, Overrun;
  logic [31:0] RxWord;
  logic [7:0]  FieldA, FieldB, FieldRes, WordCount;
  logic [3:0]  FieldSel, FieldFlag;

  int compared = 0;
  int mismatched = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int valid_cycles = 0;
  logic [31:0] exp_q[$];

  serial_frame_receiver #(.WORD_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .SerData(SerData), .SerClk(SerClk), .SerValid(SerValid),
    .RxReady(RxReady), .RxValid(RxValid), .RxWord(RxWord), .FieldA(FieldA), .FieldB(FieldB),
    .FieldRes(FieldRes), .FieldSel(FieldSel), .FieldFlag(FieldFlag), .FrameErr(FrameErr),
    .Overrun(Overrun), .WordCount(WordCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: count pulse cycles and compare every popped word against the scoreboard.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (FrameErr) ferr_cycles++;
      if (Overrun) ovr_cycles++;
      if (RxValid) valid_cycles++;
      if (RxValid && RxReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", RxWord, 32'hxxxxxxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("rx_word", RxWord, e);
          check("field_a", {24'd0, FieldA}, {24'd0, e[31:24]});
          check("field_b", {24'd0, FieldB}, {24'd0, e[23:16]});
          check("field_res", {24'd0, FieldRes}, {24'd0, e[15:8]});
          check("field_sel", {28'd0, FieldSel}, {28'd0, e[7:4]});
          check("field_flag", {28'd0, FieldFlag}, {28'd0, e[3:0]});
        end
      end
    end
  end

  // One divide-by-4 SerClk period; optionally pulse RxReady for exactly the edge after the capture edge.
  task automatic drive_bit(input logic b, input bit ready_pulse);
    SerData = b;
    SerClk  = 1'b0;
    repeat (2) @(posedge Clk);
    #1 SerClk = 1'b1;
    @(posedge Clk);
    #1 if (ready_pulse) RxReady = 1'b1;
    @(posedge Clk);
    #1 if (ready_pulse) RxReady = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input bit pulse_last);
    for (int i = 0; i < nbits; i++)
      drive_bit(w[31-i], pulse_last && (i == 31));
  endtask

  task automatic idle(input int n);
    SerClk = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    SerValid = 1'b0;
    SerClk = 1'b0;
    RxReady = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    @(posedge Clk);
    #1;
    ferr_cycles = 0;
    ovr_cycles = 0;
    valid_cycles = 0;
  endtask

  initial begin
    // Reset state
    #7 Reset = 1'b0;
    #1;
    check("rst_rx_valid", {31'd0, RxValid}, 32'd0);
    check("rst_rx_word", RxWord, 32'd0);
    check("rst_frame_err", {31'd0, FrameErr}, 32'd0);
    check("rst_overrun", {31'd0, Overrun}, 32'd0);
    check("rst_word_count", {24'd0, WordCount}, 32'd0);
    check("rst_fields", {FieldA, FieldB, FieldRes, FieldSel, FieldFlag}, 32'd0);
    @(posedge Clk);
    #1;

    // Single frame, consumer always ready
    RxReady = 1'b1;
    SerValid = 1'b1;
    exp_q.push_back(32'hAB55FF10);
    send_bits(32'hAB55FF10, 32, 1'b0);
    SerValid = 1'b0;
    idle(6);
    check("t1_queue_drained", exp_q.size(), 0);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_word_count", {24'd0, WordCount}, 32'd1);
    check("t1_frame_err", ferr_cycles, 0);

    // Three back-to-back frames into a 2-entry buffer, consumer stalled
    do_reset();
    SerValid = 1'b1;
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h80000000);
    send_bits(32'h00000001, 32, 1'b0);
    send_bits(32'h80000000, 32, 1'b0);
    send_bits(32'hFFFFFFFF, 32, 1'b0);
    SerValid = 1'b0;
    idle(4);
    check("t3_overrun_cycles", ovr_cycles, 1);
    check("t3_word_count", {24'd0, WordCount}, 32'd2);
    check("t3_frame_err", ferr_cycles, 0);
    check("t3_rx_valid_held", {31'd0, RxValid}, 32'd1);
    RxReady = 1'b1;
    idle(5);
    check("t3_queue_drained", exp_q.size(), 0);
    check("t3_rx_valid_empty", {31'd0, RxValid}, 32'd0);

    // Truncated frame, then a clean frame
    do_reset();
    RxReady = 1'b1;
    SerValid = 1'b1;
    send_bits(32'hDEADBEEF, 17, 1'b0);
    SerValid = 1'b0;
    idle(5);
    check("t4_frame_err_cycles", ferr_cycles, 1);
    check("t4_no_valid", valid_cycles, 0);
    SerValid = 1'b1;
    exp_q.push_back(32'h12345678);
    send_bits(32'h12345678, 32, 1'b0);
    SerValid = 1'b0;
    idle(5);
    check("t4_queue_drained", exp_q.size(), 0);
    check("t4_word_count", {24'd0, WordCount}, 32'd1);
    check("t4_frame_err_total", ferr_cycles, 1);

    // Full buffer with pop on the same edge as the third write
    do_reset();
    SerValid = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'h0F0F0F0F);
    exp_q.push_back(32'h13579BDF);
    send_bits(32'hA5A5A5A5, 32, 1'b0);
    send_bits(32'h0F0F0F0F, 32, 1'b0);
    send_bits(32'h13579BDF, 32, 1'b1);
    SerValid = 1'b0;
    idle(3);
    check("t5_overrun_cycles", ovr_cycles, 0);
    check("t5_word_count", {24'd0, WordCount}, 32'd3);
    check("t5_queue_left", exp_q.size(), 2);
    RxReady = 1'b1;
    idle(5);
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset mid-frame with one word buffered
    do_reset();
    SerValid = 1'b1;
    send_bits(32'h55AA33CC, 32, 1'b0);
    send_bits(32'hFFFF0000, 10, 1'b0);
    check("t6_buffered_valid", {31'd0, RxValid}, 32'd1);
    check("t6_buffered_count", {24'd0, WordCount}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("t6_async_rx_valid", {31'd0, RxValid}, 32'd0);
    check("t6_async_word_count", {24'd0, WordCount}, 32'd0);
    SerValid = 1'b0;
    SerClk = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    idle(2);
    ferr_cycles = 0;
    RxReady = 1'b1;
    SerValid = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    send_bits(32'hCAFEF00D, 32, 1'b0);
    SerValid = 1'b0;
    idle(5);
    check("t6_queue_drained", exp_q.size(), 0);
    check("t6_word_count", {24'd0, WordCount}, 32'd1);
    check("t6_frame_err", ferr_cycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
